// File: rtl/button_event_decoder_pkg.sv
// Shared types for the button event decoder: FSM state encoding and event codes.
package button_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS1   = 3'd1,
        ST_WAIT_GAP = 3'd2,
        ST_PRESS2   = 3'd3,
        ST_HELD     = 3'd4
    } state_t;

    typedef logic [1:0] ev_code_t;

    localparam ev_code_t EV_NONE   = 2'b00;
    localparam ev_code_t EV_SHORT  = 2'b01;
    localparam ev_code_t EV_LONG   = 2'b10;
    localparam ev_code_t EV_DOUBLE = 2'b11;

endpackage

// File: rtl/button_event_decoder_if.sv
// Event handshake between the decoder (master) and the mode/menu logic (slave).
//   An event is pending while event_valid=1; event_code is stable until the cycle
//   the consumer raises event_ack, after which event_valid drops on the next edge.
//   event_ack is ignored while event_valid=0. fsm_state is a debug view only.
interface button_event_if;
    import button_pkg::*;

    logic     event_valid;
    ev_code_t event_code;
    logic     overrun;
    logic     event_ack;
    state_t   fsm_state;

    modport master (
        output event_valid,
        output event_code,
        output overrun,
        output fsm_state,
        input  event_ack
    );

    modport slave (
        input  event_valid,
        input  event_code,
        input  overrun,
        input  fsm_state,
        output event_ack
    );

endinterface

// File: rtl/button_event_decoder.sv
// Classifies debounced button gestures into SHORT / LONG / DOUBLE events and
// holds each one in a valid/ack event register with a sticky overrun flag.
module button_event_decoder
    import button_pkg::*;
#(
    parameter int LONG_CYCLES = 100_000_000,
    parameter int GAP_CYCLES  = 30_000_000,
    parameter int CNT_BITS    = 27
) (
    input  logic clk,
    input  logic reset_n,
    input  logic debounced,
    button_event_if.master ev
);

    localparam logic [CNT_BITS-1:0] LONG_LAST = CNT_BITS'(LONG_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] GAP_LAST  = CNT_BITS'(GAP_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);

    logic                prev;
    logic                rise;
    logic                fall;
    state_t              state;
    state_t              state_next;
    logic [CNT_BITS-1:0] cnt;
    logic                emit;
    ev_code_t            emit_code;
    logic                event_valid_q;
    ev_code_t            event_code_q;
    logic                overrun_q;

    // prev resets high so a button held through reset must be seen low first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= 1'b1;
        end else begin
            prev <= debounced;
        end
    end

    assign rise = debounced & ~prev;
    assign fall = ~debounced & prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fall beats the long threshold in PRESS1; rise beats the gap threshold in WAIT_GAP.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (rise) state_next = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (fall)                   state_next = ST_WAIT_GAP;
                else if (cnt == LONG_LAST)  state_next = ST_HELD;
            end
            ST_WAIT_GAP: begin
                if (rise)                   state_next = ST_PRESS2;
                else if (cnt == GAP_LAST)   state_next = ST_IDLE;
            end
            ST_PRESS2: begin
                if (fall) state_next = ST_IDLE;
            end
            ST_HELD: begin
                if (fall) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        emit      = 1'b0;
        emit_code = EV_NONE;
        case (state)
            ST_PRESS1: begin
                if (!fall && cnt == LONG_LAST) begin
                    emit      = 1'b1;
                    emit_code = EV_LONG;
                end
            end
            ST_WAIT_GAP: begin
                if (!rise && cnt == GAP_LAST) begin
                    emit      = 1'b1;
                    emit_code = EV_SHORT;
                end
            end
            ST_PRESS2: begin
                if (fall) begin
                    emit      = 1'b1;
                    emit_code = EV_DOUBLE;
                end
            end
            default: begin
                emit      = 1'b0;
                emit_code = EV_NONE;
            end
        endcase
    end

    // Only the two timed states count; elsewhere cnt sits at zero and cannot wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else if (state == ST_PRESS1 || state == ST_WAIT_GAP) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_valid_q <= 1'b0;
            event_code_q  <= EV_NONE;
            overrun_q     <= 1'b0;
        end else if (emit) begin
            if (event_valid_q && !ev.event_ack) begin
                overrun_q <= 1'b1;
            end else begin
                event_valid_q <= 1'b1;
                event_code_q  <= emit_code;
            end
        end else if (event_valid_q && ev.event_ack) begin
            event_valid_q <= 1'b0;
            event_code_q  <= EV_NONE;
        end
    end

    assign ev.event_valid = event_valid_q;
    assign ev.event_code  = event_code_q;
    assign ev.overrun     = overrun_q;
    assign ev.fsm_state   = state;

endmodule
